alu_sequencer: RTL
==================

# alu_sequencer

Sequential front end for the two-operand ALU (opcode 00 ADD, 01 SUB, 10 AND, 11 OR; flags {N,Z,C}). Accepts commands over a valid/ready handshake and drives registered opcode and operands into the combinational ALU. Captures the ALU result and flags, updates an accumulator and returns the outcome over a second valid/ready handshake. It sits between a command source (test harness or simple controller) and one ALU instance of matching width.

## Interface
- W, 32, datapath width; must equal the attached ALU's W.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  ALU opcode for this command.
- cmd_use_acc  input  1  1: operand A = accumulator; 0: operand A = cmd_a.
- cmd_a  input  W  operand A when cmd_use_acc = 0.
- cmd_b  input  W  operand B.
- alu_opcode  output  2  to ALU opcode.
- alu_operand_A  output  W  to ALU operand_A.
- alu_operand_B  output  W  to ALU operand_B.
- alu_result  input  W  from ALU alu_result.
- alu_flags  input  3  from ALU flags {N,Z,C}.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  W  captured result.
- rsp_flags  output  3  captured flags {N,Z,C}.
- acc  output  W  accumulator (last completed result).
- op_count  output  16  completed-operation counter.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready = 1. On cmd_valid, the clock edge registers alu_opcode = cmd_op, alu_operand_A = (cmd_use_acc ? acc : cmd_a) and alu_operand_B = cmd_b, then moves to EXEC.
- EXEC: the ALU evaluates the registered operands combinationally. The closing edge captures rsp_result = alu_result, rsp_flags = alu_flags and acc = alu_result, increments op_count, and moves to RESP.
- RESP: rsp_valid = 1, and rsp_result/rsp_flags are held stable. When rsp_ready = 1 at an edge, the state moves to IDLE. Otherwise it stays in RESP indefinitely.
- cmd_ready = 0 in EXEC and RESP. A command presented then is not consumed and must be held by the source.
- ALU-side outputs hold their last values outside the accept edge; they are never driven to X or zero between commands.
- The sequencer passes flags through unmodified; it does not reinterpret C. C is the carry of A+B regardless of opcode, per the ALU definition.
- op_count wraps from 0xFFFF to 0x0000 with no other effect.
- The accumulator is written only by completed operations. cmd_use_acc reads the acc value present at the accept edge.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state = IDLE. cmd_ready = 1, rsp_valid = 0, busy = 0. rsp_result, rsp_flags, acc, op_count, alu_opcode, alu_operand_A and alu_operand_B are all 0.
- Command accepted at edge k: ALU inputs are valid after edge k. rsp_valid, acc and op_count update at edge k+1.
- With rsp_ready held high, rsp_valid lasts one cycle (edge k+1 to k+2), and cmd_ready returns high after edge k+2.
- Peak throughput is one command per 3 cycles. Each cycle of rsp_ready low adds one cycle.
- A response is consumed only in RESP, so rsp_ready in IDLE/EXEC is ignored.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded, no response is issued, and all registers clear immediately.
- Only one command can be outstanding at a time, so simultaneous cmd_valid and rsp_ready interact only through the FSM, with no bypass.

## Test plan
- Reset, then ADD a=3 b=4, rsp_ready=1: rsp_valid pulses 1 cycle at accept+1 with rsp_result=7 and flags=000; acc=7; op_count=1; cmd_ready high again at accept+2.
- After the above, SUB use_acc=1 b=10: result 0xFFFFFFFD, flags=100 (N=1; 7+10 produces no carry); acc=0xFFFFFFFD.
- ADD a=0xFFFFFFFF b=1: result 0 and flags=011. Hold rsp_ready=0 for 5 cycles: rsp_valid and data stay stable and cmd_ready stays 0. A second cmd_valid during the hold is not accepted until after the response is consumed.
- AND a=0xF0F0F0F0 b=0x0F0F0F0F: result 0, flags=010; then OR with the same operands gives 0xFFFFFFFF with flags=100.
- Assert reset_n low during EXEC: outputs clear asynchronously, no rsp_valid is seen, acc=0 and op_count=0, and the sequencer is in IDLE with cmd_ready=1 after release.
- Preload op_count to 0xFFFF (via 65535 commands or force), then complete one op: op_count becomes 0x0000.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequential front end for a two-operand combinational ALU: accepts one command,
// drives registered operands, captures result/flags into an accumulator and returns a response.
module alu_sequencer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_use_acc,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [1:0]   alu_opcode,
  output logic [W-1:0] alu_operand_A,
  output logic [W-1:0] alu_operand_B,
  input  logic [W-1:0] alu_result,
  input  logic [2:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_flags,
  output logic [W-1:0] acc,
  output logic [15:0]  op_count,
  output logic         busy
);

  localparam int unsigned OP_W   = 2;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic [OP_W-1:0]   alu_opcode_q;
  logic [W-1:0]      alu_operand_a_q;
  logic [W-1:0]      alu_operand_b_q;
  logic [W-1:0]      rsp_result_q;
  logic [FLAG_W-1:0] rsp_flags_q;
  logic [W-1:0]      acc_q;
  logic [CNT_W-1:0]  op_count_q;

  logic accept;
  logic complete;

  assign accept   = (state_q == S_IDLE) && cmd_valid;
  assign complete = (state_q == S_EXEC);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the next state so they leave a flop
  always_comb begin
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    busy_d      = 1'b1;
    case (state_d)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      S_RESP:  rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // ALU-side operand registers hold their value between commands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_opcode_q    <= '0;
      alu_operand_a_q <= '0;
      alu_operand_b_q <= '0;
    end else if (accept) begin
      alu_opcode_q    <= cmd_op;
      alu_operand_a_q <= cmd_use_acc ? acc_q : cmd_a;
      alu_operand_b_q <= cmd_b;
    end
  end

  // Result capture, accumulator and wrapping operation counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      acc_q        <= '0;
      op_count_q   <= '0;
    end else if (complete) begin
      rsp_result_q <= alu_result;
      rsp_flags_q  <= alu_flags;
      acc_q        <= alu_result;
      op_count_q   <= op_count_q + CNT_W'(1);
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign busy          = busy_q;
  assign alu_opcode    = alu_opcode_q;
  assign alu_operand_A = alu_operand_a_q;
  assign alu_operand_B = alu_operand_b_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_flags     = rsp_flags_q;
  assign acc           = acc_q;
  assign op_count      = op_count_q;

endmodule
